// File: rtl/int_to_fp16_pipe.sv
// Three-stage integer-to-binary16 converter with valid/ready stall pipeline.
// Define INT_TO_FP16_RNE_EN for round-to-nearest-even with overflow to inf; otherwise truncation with saturation.
module int_to_fp16_pipe #(
    parameter int unsigned INT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_fp,
    output logic             out_inexact,
    output logic             out_overflow
);

    localparam int unsigned PW = (INT_W > 2) ? $clog2(INT_W) : 1;
    localparam int unsigned XW = INT_W + 10;

    logic adv1, adv2, adv3;

    logic             s1_valid_q, s1_sign_q, s1_sign_d;
    logic [INT_W-1:0] s1_mag_q, s1_mag_d;

    logic             s2_valid_q, s2_sign_q, s2_zero_q, s2_zero_d;
    logic [PW-1:0]    s2_msb_q, s2_msb_d;
    logic [INT_W-2:0] s2_norm_q;
    logic [INT_W-1:0] norm_full;

    logic             out_valid_q, out_inexact_q, out_overflow_q;
    logic [15:0]      out_fp_q;
    logic [15:0]      fp_d;
    logic             inexact_d, overflow_d;

    logic [XW-1:0]    ext;
    logic [9:0]       mant, mant_r;
    logic             guard, sticky, ovf;
    logic [6:0]       exp7;
    logic [14:0]      sat;

    // Each stage moves when its slot is empty or the next stage is moving.
    assign adv3     = !out_valid_q || out_ready;
    assign adv2     = !s2_valid_q || adv3;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    always_comb begin
        s1_sign_d = 1'b0;
        s1_mag_d  = in_data;
        if (in_signed && in_data[INT_W-1]) begin
            s1_sign_d = 1'b1;
            s1_mag_d  = (~in_data) + INT_W'(1);
        end
    end

    // Leading-one position, then shift it up to the top bit.
    always_comb begin
        s2_msb_d = '0;
        for (int unsigned i = 0; i < INT_W; i++) begin
            if (s1_mag_q[i]) s2_msb_d = PW'(i);
        end
        norm_full = s1_mag_q << (PW'(INT_W - 1) - s2_msb_d);
        s2_zero_d = !norm_full[INT_W-1];
    end

    always_comb begin
        ext    = {s2_norm_q, 11'b0};
        mant   = ext[XW-1 -: 10];
        guard  = ext[INT_W-1];
        sticky = |ext[INT_W-2:0];
        exp7   = 7'(s2_msb_q) + 7'd15;
`ifdef INT_TO_FP16_RNE_EN
        begin
            logic [10:0] mant11;
            mant11 = {1'b0, mant} + 11'(guard & (sticky | mant[0]));
            exp7   = exp7 + 7'(mant11[10]);
            mant_r = mant11[9:0];
            sat    = 15'h7C00;
        end
`else
        mant_r = mant;
        sat    = 15'h7BFF;
`endif
        ovf        = (exp7 >= 7'd31);
        fp_d       = {s2_sign_q, exp7[4:0], mant_r};
        inexact_d  = guard | sticky;
        overflow_d = 1'b0;
        if (s2_zero_q) begin
            fp_d      = 16'h0000;
            inexact_d = 1'b0;
        end else if (ovf) begin
            fp_d       = {s2_sign_q, sat};
            inexact_d  = 1'b1;
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_mag_q  <= s1_mag_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b1;
            s2_msb_q   <= '0;
            s2_norm_q  <= '0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s2_zero_d;
                s2_msb_q  <= s2_msb_d;
                s2_norm_q <= norm_full[INT_W-2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_fp_q       <= 16'h0000;
            out_inexact_q  <= 1'b0;
            out_overflow_q <= 1'b0;
        end else if (adv3) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_fp_q       <= fp_d;
                out_inexact_q  <= inexact_d;
                out_overflow_q <= overflow_d;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_fp       = out_fp_q;
    assign out_inexact  = out_inexact_q;
    assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_int_to_fp16_pipe.sv
// Scoreboard bench for int_to_fp16_pipe at INT_W = 8/16/32/64 driven in lockstep.
module tb_int_to_fp16_pipe;

    localparam int W [4] = '{8, 16, 32, 64};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] din = '0;

    logic        rdy [4];
    logic        ov  [4];
    logic [15:0] fp  [4];
    logic        inx [4];
    logic        ofl [4];

    logic [17:0] sbq [4][$];
    bit          use_dir = 1'b0;
    logic [17:0] dir_exp = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    int_to_fp16_pipe #(.INT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(din[7:0]), .in_signed(in_signed), .out_valid(ov[0]), .out_ready(out_ready),
        .out_fp(fp[0]), .out_inexact(inx[0]), .out_overflow(ofl[0]));
    int_to_fp16_pipe #(.INT_W(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(din[15:0]), .in_signed(in_signed), .out_valid(ov[1]), .out_ready(out_ready),
        .out_fp(fp[1]), .out_inexact(inx[1]), .out_overflow(ofl[1]));
    int_to_fp16_pipe #(.INT_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(din[31:0]), .in_signed(in_signed), .out_valid(ov[2]), .out_ready(out_ready),
        .out_fp(fp[2]), .out_inexact(inx[2]), .out_overflow(ofl[2]));
    int_to_fp16_pipe #(.INT_W(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
        .in_data(din), .in_signed(in_signed), .out_valid(ov[3]), .out_ready(out_ready),
        .out_fp(fp[3]), .out_inexact(inx[3]), .out_overflow(ofl[3]));

    // Reference: exact integer quotient/remainder rounding, result packed {overflow, inexact, fp}.
    function automatic logic [17:0] ref_conv(input logic [63:0] v, input int w, input bit sgn);
        logic [63:0] mask, mag, q, rem, half;
        int          e;
        bit          neg, inexact, ovf;
        logic [15:0] res;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        mag  = v & mask;
        neg  = 1'b0;
        if (sgn && mag[w-1]) begin
            neg = 1'b1;
            mag = ((~mag) + 64'd1) & mask;
        end
        if (mag == 64'd0) return 18'h0;
        e = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) e = i;
        rem = '0;
        if (e <= 10) q = mag << (10 - e);
        else begin
            q   = mag >> (e - 10);
            rem = mag & ((64'd1 << (e - 10)) - 64'd1);
        end
        inexact = (rem != 64'd0);
`ifdef INT_TO_FP16_RNE_EN
        if (e > 10) begin
            half = 64'd1 << (e - 11);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end
        if (q == 64'd2048) begin
            q = 64'd1024;
            e = e + 1;
        end
`else
        half = '0;
`endif
        ovf = (e > 15);
        if (ovf) begin
            inexact = 1'b1;
`ifdef INT_TO_FP16_RNE_EN
            res = {neg, 15'h7C00};
`else
            res = {neg, 15'h7BFF};
`endif
        end else res = {neg, 5'(e + 15), q[9:0]};
        return {ovf, inexact, res};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push on accepted input, pop and compare on accepted output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && rdy[2])
                for (int i = 0; i < 4; i++)
                    sbq[i].push_back((i == 2 && use_dir) ? dir_exp : ref_conv(din, W[i], in_signed));
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && out_ready) begin
                    n_cmp++;
                    assert (sbq[i].size() != 0) else begin
                        n_err++;
                        $error("FAIL w%0d unexpected output: observed %0h expected none", W[i], fp[i]);
                    end
                    if (sbq[i].size() != 0)
                        chk($sformatf("w%0d result", W[i]), 64'({ofl[i], inx[i], fp[i]}), 64'(sbq[i].pop_front()));
                end
            end
            chk("in_ready lockstep", 64'({rdy[0], rdy[1], rdy[3]}), 64'({3{rdy[2]}}));
        end
    end

    task automatic drive(input logic [63:0] d, input bit s, input logic [17:0] e);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        use_dir = 1'b1;
        din = d; in_signed = s; dir_exp = e; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = rdy[2];
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("accept", 64'(acc), 64'd1);
    endtask

    task automatic latency_one();
        int n;
        n = 0;
        use_dir = 1'b1;
        dir_exp = {2'b00, 16'h3C00};
        din = 64'd1; in_signed = 1'b0; in_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) in_valid = 1'b0;
        end while (!ov[2] && n < 10);
        chk("latency", 64'(n), 64'd3);
    endtask

    logic [63:0] dv [10];
    bit          ds [10];
    logic [17:0] de [10];

    initial begin
        dv[0] = 64'd0;          ds[0] = 0; de[0] = {2'b00, 16'h0000};
        dv[1] = 64'd1;          ds[1] = 0; de[1] = {2'b00, 16'h3C00};
        dv[2] = 64'hFFFFFFFF;   ds[2] = 1; de[2] = {2'b00, 16'hBC00};
        dv[3] = 64'd2049;       ds[3] = 0; de[3] = {2'b01, 16'h6800};
        dv[4] = 64'd65504;      ds[4] = 0; de[4] = {2'b00, 16'h7BFF};
`ifdef INT_TO_FP16_RNE_EN
        dv[5] = 64'hFFFFFFFF;   ds[5] = 0; de[5] = {2'b11, 16'h7C00};
        dv[6] = 64'd2051;       ds[6] = 0; de[6] = {2'b01, 16'h6802};
        dv[7] = 64'd65520;      ds[7] = 0; de[7] = {2'b11, 16'h7C00};
        dv[8] = 64'h80000000;   ds[8] = 1; de[8] = {2'b11, 16'hFC00};
        dv[9] = 64'hFFFEEE90;   ds[9] = 1; de[9] = {2'b11, 16'hFC00};
`else
        dv[5] = 64'hFFFFFFFF;   ds[5] = 0; de[5] = {2'b11, 16'h7BFF};
        dv[6] = 64'd2051;       ds[6] = 0; de[6] = {2'b01, 16'h6801};
        dv[7] = 64'd65520;      ds[7] = 0; de[7] = {2'b01, 16'h7BFF};
        dv[8] = 64'h80000000;   ds[8] = 1; de[8] = {2'b11, 16'hFBFF};
        dv[9] = 64'hFFFEEE90;   ds[9] = 1; de[9] = {2'b11, 16'hFBFF};
`endif

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("reset out_valid", 64'(ov[2]), 64'd0);
        chk("reset out_fp", 64'(fp[2]), 64'h0);
        chk("reset flags", 64'({inx[2], ofl[2]}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset in_ready", 64'(rdy[2]), 64'd1);

        latency_one();

        // Directed values back-to-back
        for (int i = 0; i < 10; i++) drive(dv[i], ds[i], de[i]);
        repeat (6) @(posedge clk);
        #1 chk("directed drained", 64'(sbq[2].size()), 64'd0);

        // Backpressure: five back-to-back inputs, output stalled for six cycles
        out_ready = 1'b0;
        fork
            begin
                drive(64'd1, 0, {2'b00, 16'h3C00});
                drive(64'd2, 0, {2'b00, 16'h4000});
                drive(64'd3, 0, {2'b00, 16'h4200});
                drive(64'd4, 0, {2'b00, 16'h4400});
                drive(64'd5, 0, {2'b00, 16'h4500});
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp in_ready low", 64'(rdy[2]), 64'd0);
                chk("bp out_valid", 64'(ov[2]), 64'd1);
                chk("bp head fp", 64'(fp[2]), 64'h3C00);
                @(posedge clk);
                #1 chk("bp hold fp", 64'(fp[2]), 64'h3C00);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1 chk("bp drained", 64'(sbq[2].size()), 64'd0);

        // Reset with three results in flight
        out_ready = 1'b0;
        drive(64'd7, 0, {2'b00, 16'h4700});
        drive(64'd8, 0, {2'b00, 16'h4800});
        drive(64'd9, 0, {2'b00, 16'h4880});
        chk("pre-reset out_valid", 64'(ov[2]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", 64'(ov[2]), 64'd0);
        chk("mid reset out_fp", 64'(fp[2]), 64'h0);
        for (int i = 0; i < 4; i++) sbq[i].delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        chk("post reset in_ready", 64'(rdy[2]), 64'd1);
        repeat (6) @(posedge clk);
        #1 latency_one();
        repeat (4) @(posedge clk);

        // Random regression against the reference model
        #1 use_dir = 1'b0;
        repeat (600) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_signed = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 3) != 0);
            din = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: din = 64'($urandom_range(0, 70000));
                1: din = 64'(65504 + $urandom_range(0, 32));
                2: din = {$urandom, 32'h0};
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("w%0d random drained", W[i]), 64'(sbq[i].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
